// File: rtl/signal_phase_controller_if.sv
// signal_phase_controller_if: green-time inputs and phase/lamp/timer outputs of the junction controller
interface signal_phase_controller_if;
    logic [7:0] TGn;
    logic [7:0] TGe;
    logic [7:0] TGs;
    logic [7:0] TGw;
    logic [3:0] p_s;
    logic [2:0] L_n;
    logic [2:0] L_e;
    logic [2:0] L_s;
    logic [2:0] L_w;
    logic [7:0] t_rem;
    logic       cycle_done;
    modport master (output TGn, TGe, TGs, TGw, input p_s, L_n, L_e, L_s, L_w, t_rem, cycle_done);
    modport slave  (input TGn, TGe, TGs, TGw, output p_s, L_n, L_e, L_s, L_w, t_rem, cycle_done);
endinterface

// File: rtl/signal_phase_controller.sv
// signal_phase_controller: N->E->S->W junction sequencer with tick-prescaled phase timers
module signal_phase_controller #(
    parameter int TICK_DIV  = 50,
    parameter int T_YELLOW  = 3,
    parameter int T_ALLRED  = 2,
    parameter int MIN_GREEN = 5
) (
    input logic clk,
    input logic reset,
    signal_phase_controller_if.slave bus
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [3:0] {
        ALL_RED, N_GREEN, N_YELLOW, E_GREEN, E_YELLOW, S_GREEN, S_YELLOW, W_GREEN, W_YELLOW
    } phase_t;
    logic [PW-1:0] r_pre;
    logic          r_run;
    logic [3:0]    r_ps;
    logic [7:0]    r_t;
    logic [11:0]   r_l;
    logic          r_done;
    logic          w_tick;
    logic          w_ill;
    logic          w_go;
    logic [3:0]    w_nxt;
    logic [7:0]    w_tg;
    logic [7:0]    w_dur;
    logic [11:0]   w_lamps;
    function automatic logic [2:0] lamp(input logic [3:0] p, input logic [3:0] g);
        return p == g ? 3'b001 : p == g + 4'd1 ? 3'b010 : 3'b100;
    endfunction
    // Illegal codes fall through the same advance path, landing on ALL_RED immediately
    always_comb begin
        w_tick  = r_pre == PW'(TICK_DIV - 1);
        w_ill   = r_ps > W_YELLOW;
        w_go    = w_ill || (w_tick && r_t <= 8'd1);
        w_nxt   = r_ps >= W_YELLOW ? ALL_RED : r_ps + 4'd1;
        w_tg    = w_nxt == N_GREEN ? bus.TGn : w_nxt == E_GREEN ? bus.TGe :
                  w_nxt == S_GREEN ? bus.TGs : bus.TGw;
        w_dur   = w_nxt == ALL_RED ? 8'(T_ALLRED) : !w_nxt[0] ? 8'(T_YELLOW) :
                  w_tg < 8'(MIN_GREEN) ? 8'(MIN_GREEN) : w_tg;
        w_lamps = {lamp(w_nxt, N_GREEN), lamp(w_nxt, E_GREEN), lamp(w_nxt, S_GREEN), lamp(w_nxt, W_GREEN)};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre  <= '0;
            r_run  <= 1'b0;
            r_ps   <= ALL_RED;
            r_t    <= '0;
            r_l    <= {4{3'b100}};
            r_done <= 1'b0;
        end else begin
            r_pre  <= w_tick ? '0 : r_pre + 1'b1;
            r_run  <= 1'b1;
            r_done <= r_run && w_go && r_ps == W_YELLOW;
            if (!r_run) begin
                r_ps <= ALL_RED;
                r_t  <= 8'(T_ALLRED);
            end else if (w_go) begin
                r_ps <= w_nxt;
                r_t  <= w_dur;
                r_l  <= w_lamps;
            end else if (w_tick) begin
                r_t <= r_t - 8'd1;
            end
        end
    end
    assign bus.p_s        = r_ps;
    assign bus.t_rem      = r_t;
    assign bus.cycle_done = r_done;
    assign {bus.L_n, bus.L_e, bus.L_s, bus.L_w} = r_l;
endmodule
